// File: rtl/barrett_pipe_reducer.sv
// Three-stage Barrett reducer computing in_x mod Q with valid/ready on both sides.
// All stages advance together on adv, so a stalled output freezes the whole pipe.
module barrett_pipe_reducer #(
    parameter int          DATA_W = 64,
    parameter int unsigned Q      = 7681,
    parameter int          TAG_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_x,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_r,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_range_err
);

    localparam int              K  = $clog2(Q + 1);
    localparam logic [2*K+1:0]  MU = (2*K+2)'((64'd1 << (2*K)) / 64'(Q));
    localparam logic [2*DATA_W-1:0] QQ = (2*DATA_W)'(64'(Q) * 64'(Q));
    localparam logic [K+1:0]    QW = (K+2)'(Q);

    function automatic logic [K+1:0] cond_sub(input logic [K+1:0] v);
        return (v >= QW) ? v - QW : v;
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage p0: quotient estimate, range check, low residue bits of in_x
    logic               vld_p0;
    logic               err_p0;
    logic [TAG_W-1:0]   tag_p0;
    logic [K+1:0]       x_p0;
    logic [K:0]         q3_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   vld_p0 <= 1'b0;
        else if (adv) vld_p0 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            err_p0 <= (in_x >= QQ);
            tag_p0 <= in_tag;
            x_p0   <= in_x[K+1:0];
            q3_p0  <= (K+1)'(((2*K+2)'(in_x[K-1 +: K+1]) * MU) >> (K+1));
        end
    end

    // Stage p1: r = x - q3*Q modulo 2^(K+2), exact while r < 3Q
    logic               vld_p1;
    logic               err_p1;
    logic [TAG_W-1:0]   tag_p1;
    logic [K+1:0]       r_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   vld_p1 <= 1'b0;
        else if (adv) vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            err_p1 <= err_p0;
            tag_p1 <= tag_p0;
            r_p1   <= x_p0 - (K+2)'((K+2)'(q3_p0) * QW);
        end
    end

    // Stage p2: two conditional corrections; out-of-range samples report zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_r         <= '0;
            out_tag       <= '0;
            out_range_err <= 1'b0;
        end else if (adv) begin
            out_valid     <= vld_p1;
            out_r         <= err_p1 ? '0 : DATA_W'(cond_sub(cond_sub(r_p1)));
            out_tag       <= tag_p1;
            out_range_err <= err_p1;
        end
    end

endmodule

// File: tb/tb_barrett_pipe_reducer.sv
// Bench for barrett_pipe_reducer: reset, latency, edge values, range error,
// backpressure, mid-flight reset and a long random stream against x % Q.
module tb_barrett_pipe_reducer;

    localparam int              DATA_W = 64;
    localparam int              TAG_W  = 3;
    localparam int unsigned     Q      = 7681;
    localparam logic [127:0]    QQ     = 128'd58997761;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       in_x;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_r;
    logic [TAG_W-1:0]   out_tag;
    logic               out_range_err;

    int total = 0;
    int bad   = 0;

    barrett_pipe_reducer #(.DATA_W(DATA_W), .Q(Q), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_tag(out_tag), .out_range_err(out_range_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] model_r(input logic [127:0] x);
        logic [127:0] m;
        if (x >= QQ) return '0;
        m = x % 128'(Q);
        return m[DATA_W-1:0];
    endfunction

    // Drives one cycle at the falling edge; reports whether each side transfers.
    task automatic step(input logic v, input logic [127:0] x, input logic [TAG_W-1:0] t,
                        input logic ordy, output logic acc, output logic con);
        @(negedge clk);
        in_valid  = v;
        in_x      = x;
        in_tag    = t;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        con = out_valid && ordy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_r !== '0 || out_tag !== '0 || out_range_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b r=%0d tag=%0d err=%b, want all 0",
                     out_valid, out_r, out_tag, out_range_err);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic acc, con;
        int lat;
        lat = -1;
        step(1'b1, 128'd1233925, 3'd3, 1'b1, acc, con);
        total++;
        if (acc !== 1'b1) begin
            bad++;
            $display("FAIL basic_accept: in_ready=%b want 1", in_ready);
        end
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, '0, '0, 1'b1, acc, con);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 3", lat);
        end
        total++;
        if (out_r !== 64'd4965 || out_range_err !== 1'b0 || out_tag !== 3'd3) begin
            bad++;
            $display("FAIL basic_value: r=%0d err=%b tag=%0d want r=4965 err=0 tag=3",
                     out_r, out_range_err, out_tag);
        end
        step(1'b0, '0, '0, 1'b1, acc, con);
    endtask

    task automatic test_edges;
        logic [127:0]     xs[7];
        logic [TAG_W-1:0] ts[7];
        logic [DATA_W-1:0] er[$];
        logic [TAG_W-1:0]  et[$];
        logic              ee[$];
        logic acc, con;
        int sent, got, cyc;
        xs = '{128'd0, 128'd7680, 128'd7681, 128'd58997760, 128'd58997761,
               {128{1'b1}}, 128'd15362};
        ts = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        sent = 0; got = 0; cyc = 0;
        while (got < 7 && cyc < 60) begin
            step(sent < 7, (sent < 7) ? xs[sent] : '0, (sent < 7) ? ts[sent] : '0,
                 1'b1, acc, con);
            if (out_valid === 1'b1) begin
                total++;
                if (er.size() == 0) begin
                    bad++;
                    $display("FAIL edges_spurious: out_valid with nothing pending");
                end else if (out_r !== er[0] || out_tag !== et[0] || out_range_err !== ee[0]) begin
                    bad++;
                    $display("FAIL edges_value: r=%0d tag=%0d err=%b want r=%0d tag=%0d err=%b",
                             out_r, out_tag, out_range_err, er[0], et[0], ee[0]);
                end
            end
            if (con && er.size() != 0) begin
                void'(er.pop_front()); void'(et.pop_front()); void'(ee.pop_front());
                got++;
            end
            if (acc) begin
                er.push_back(model_r(xs[sent]));
                et.push_back(ts[sent]);
                ee.push_back(xs[sent] >= QQ);
                sent++;
            end
            cyc++;
        end
        total++;
        if (got != 7) begin
            bad++;
            $display("FAIL edges_count: got %0d outputs want 7", got);
        end
    endtask

    task automatic test_backpressure;
        logic [DATA_W-1:0] er[$];
        logic [TAG_W-1:0]  et[$];
        logic acc, con, ordy;
        logic [127:0] x;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 300) begin
            x    = 128'($urandom % 32'd58997761);
            ordy = 1'($urandom % 2);
            step(sent < 8, x, TAG_W'(sent), ordy, acc, con);
            if (out_valid === 1'b1) begin
                total++;
                if (er.size() == 0) begin
                    bad++;
                    $display("FAIL bp_spurious: out_valid with nothing pending, tag=%0d", out_tag);
                end else if (out_r !== er[0] || out_tag !== et[0] || out_range_err !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_value: r=%0d tag=%0d err=%b want r=%0d tag=%0d err=0",
                             out_r, out_tag, out_range_err, er[0], et[0]);
                end
            end
            if (con && er.size() != 0) begin
                void'(er.pop_front()); void'(et.pop_front());
                got++;
            end
            if (acc) begin
                er.push_back(model_r(x));
                et.push_back(TAG_W'(sent));
                sent++;
            end
            cyc++;
        end
        total++;
        if (got != 8 || sent != 8) begin
            bad++;
            $display("FAIL bp_count: sent=%0d got=%0d want 8/8", sent, got);
        end
        repeat (6) begin
            step(1'b0, '0, '0, 1'b1, acc, con);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL bp_extra: out_valid=%b after drain want 0", out_valid);
            end
        end
    endtask

    task automatic test_reset_midflight;
        logic acc, con;
        int stale;
        for (int i = 0; i < 3; i++) step(1'b1, 128'(100 + i), TAG_W'(i + 1), 1'b1, acc, con);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        total++;
        if (out_valid !== 1'b0 || out_r !== '0 || out_tag !== '0 || out_range_err !== 1'b0) begin
            bad++;
            $display("FAIL midreset_clear: valid=%b r=%0d tag=%0d err=%b want all 0",
                     out_valid, out_r, out_tag, out_range_err);
        end
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, '0, 1'b1, acc, con);
            if (out_valid !== 1'b0) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++;
            $display("FAIL midreset_stale: %0d stale outputs want 0", stale);
        end
    endtask

    task automatic test_random;
        logic [DATA_W-1:0] er[$];
        logic acc, con;
        logic [127:0] x;
        int sent, got, cyc, n;
        n = 10000;
        sent = 0; got = 0; cyc = 0;
        while (got < n && cyc < n + 50) begin
            x = 128'($urandom % 32'd58997761);
            step(sent < n, x, TAG_W'($urandom), 1'b1, acc, con);
            if (out_valid === 1'b1) begin
                total++;
                if (er.size() == 0) begin
                    bad++;
                    $display("FAIL rand_spurious: out_valid with nothing pending");
                end else if (out_r !== er[0] || out_range_err !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_value: r=%0d err=%b want r=%0d err=0",
                             out_r, out_range_err, er[0]);
                end
            end
            if (con && er.size() != 0) begin
                void'(er.pop_front());
                got++;
            end
            if (acc) begin
                er.push_back(model_r(x));
                sent++;
            end
            cyc++;
        end
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL rand_count: got %0d outputs want %0d", got, n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
